// File: rtl/cmd_queue.sv
// cmd_queue: command FIFO feeding the issuer. The host pushes commands. The
// issuer pops them with a held read request, or returns dependency-blocked
// commands with a held writeback request. One ack line answers both kinds.
// RESV slots are kept back from the host so a writeback always finds room.
//
// Ports:
//   i_clk, i_rstn              clock, asynchronous active-low reset
//   i_push, i_push_cmd         host write strobe and command
//   o_full, o_overflow         host push refused this cycle / sticky drop flag
//   i_rd                       issuer read request, held until ack
//   i_wb, i_wb_cmd             issuer writeback request (held) and command
//   o_ack                      one-cycle ack for either request
//   o_cmd                      last popped command, registered
//   o_empty, o_count           occupancy status
//
// Build option: define CMDQ_WB_HEAD_EN to insert writebacks at head-1, so a
// returned command is offered again first. Otherwise writebacks append at tail.

package cmd_pkg;
   typedef struct packed {
      logic [7:0]  id;
      logic [3:0]  op;
      logic [19:0] arg;
   } cmd_t;
endpackage

// purpose : host/issuer command FIFO with reserved writeback slots
// latency : ack one cycle after the request is sampled in IDLE; o_cmd updates with the ack
// backpr. : host sees o_full (pushes then dropped, flagged); issuer requests wait in IDLE
module cmd_queue
   import cmd_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int RESV  = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rstn,
   input  logic                     i_push,
   input  cmd_t                     i_push_cmd,
   output logic                     o_full,
   output logic                     o_overflow,
   input  logic                     i_rd,
   input  logic                     i_wb,
   input  cmd_t                     i_wb_cmd,
   output logic                     o_ack,
   output cmd_t                     o_cmd,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] HOST_LIMIT = CW'(DEPTH - RESV);
   localparam logic [CW-1:0] CAPACITY   = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   head_q, tail_q;
   logic [CW-1:0]   count_q;
   cmd_t            mem [DEPTH];

   logic            wb_go, rd_go, push_go;

   // Arbitration happens only in IDLE; a writeback with room beats a read.
   // A read still proceeds when a pending writeback has no room to land.
   always_comb begin
      wb_go = (state_q == IDLE) && i_wb && (count_q < CAPACITY);
      rd_go = (state_q == IDLE) && !wb_go && i_rd && (count_q != '0);
   end

`ifdef CMDQ_WB_HEAD_EN
   // Writeback goes to head-1 and the host to tail; with the host capped at
   // DEPTH-RESV there are always two free slots, so the two never collide.
   assign o_full = (count_q >= HOST_LIMIT);
`else
   // Only one tail write per edge: a writeback being accepted blocks the host.
   assign o_full = (count_q >= HOST_LIMIT) || wb_go;
`endif

   assign push_go = i_push && !o_full;
   assign o_ack   = (state_q == ACK);
   assign o_empty = (count_q == '0);
   assign o_count = count_q;

   // Handshake FSM: HOLD waits for both requests to drop so a request that is
   // still held after its ack cannot be served twice.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (wb_go || rd_go) state_d = ACK;
         ACK:     state_d = HOLD;
         HOLD:    if (!i_rd && !i_wb) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= IDLE;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         o_cmd      <= '0;
         o_overflow <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_q + CW'(wb_go) + CW'(push_go) - CW'(rd_go);
         if (i_push && o_full)
            o_overflow <= 1'b1;
         if (rd_go)
            o_cmd <= mem[head_q];
`ifdef CMDQ_WB_HEAD_EN
         if (wb_go)
            head_q <= head_q - 1'b1;
         else if (rd_go)
            head_q <= head_q + 1'b1;
         if (push_go)
            tail_q <= tail_q + 1'b1;
`else
         if (rd_go)
            head_q <= head_q + 1'b1;
         if (wb_go || push_go)
            tail_q <= tail_q + 1'b1;
`endif
      end
   end

   // Storage carries no reset; contents are only read behind a nonzero count.
`ifdef CMDQ_WB_HEAD_EN
   always_ff @(posedge i_clk) begin
      if (wb_go)
         mem[head_q - 1'b1] <= i_wb_cmd;
      if (push_go)
         mem[tail_q] <= i_push_cmd;
   end
`else
   always_ff @(posedge i_clk) begin
      if (wb_go)
         mem[tail_q] <= i_wb_cmd;
      else if (push_go)
         mem[tail_q] <= i_push_cmd;
   end
`endif

endmodule
